// File: rtl/arb_pkg.sv
// Shared arbiter helpers: source-index width, index type and pointer advance.
// Imported by the round-robin picker, the interface and the registered arbiter.
package arb_pkg;

    localparam int MAX_REQ = 16;

    function automatic int src_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef logic [src_w(MAX_REQ)-1:0] src_idx_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_reg_arbiter_if.sv
// Requester-side and sink-side handshake bundle of the registered arbiter.
// slave is the arbiter's view, master is the producers/consumer view.
interface rr_reg_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 8
);
    import arb_pkg::*;

    localparam int SW = src_w(N_REQ);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic                out_valid;
    logic [DW-1:0]       out_data;
    logic [SW-1:0]       out_src;
    logic                out_ready;

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_src
    );

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_src
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Produces both a one-hot grant and its binary index.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] idx,
    output logic          any
);

    logic [SW-1:0] k;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = '0;
        for (int i = 0; i < N; i++) begin
            k = SW'((int'(ptr) + i) % N);
            if (!any && req[k]) begin
                any    = 1'b1;
                gnt[k] = 1'b1;
                idx    = k;
            end
        end
    end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter feeding one registered output stage.
// Output register refills in the same cycle it drains, so no bubbles.
module rr_reg_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = 8
) (
    input logic           clk,
    input logic           rst,
    rr_reg_arbiter_if.slave bus
);

    localparam int SW = src_w(N_REQ);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [SW-1:0]    ptr;
    logic [SW-1:0]    gnt_idx;
    logic [N_REQ-1:0] gnt;
    logic             any;
    logic             drain;
    logic             can_take;
    logic             accept;
    logic [DW-1:0]    data_q;
    logic [SW-1:0]    src_q;

    rr_pick #(
        .N  (N_REQ),
        .SW (SW)
    ) u_pick (
        .req (bus.req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (any)
    );

    assign drain         = bus.out_valid & bus.out_ready;
    assign can_take      = ~bus.out_valid | bus.out_ready;
    assign accept        = can_take & any;
    assign bus.req_ready = can_take ? gnt : '0;
    assign bus.out_valid = (state == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_src   = src_q;

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY:   if (accept) state_nxt = FULL;
            FULL:    if (drain && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // Payload and pointer only move on accept; a plain drain keeps them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= EMPTY;
            data_q <= '0;
            src_q  <= '0;
            ptr    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                data_q <= bus.req_data[int'(gnt_idx)*DW +: DW];
                src_q  <= gnt_idx;
                ptr    <= SW'(rr_next(int'(gnt_idx), N_REQ));
            end
        end
    end

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Bench for rr_reg_arbiter: directed literal cases plus a random run
// checked every cycle against a behavioural round-robin model.
module tb_rr_reg_arbiter;
    import arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    rr_reg_arbiter_if #(.N_REQ(N), .DW(DW)) bus ();

    rr_reg_arbiter #(.N_REQ(N), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    bit         m_valid;
    logic [7:0] m_data;
    int         m_src;
    int         m_ptr;
    int         m_gnt;
    bit         m_took;
    int         waitc [N];
    bit         run_cmp = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Winner = valid requester with smallest forward distance from ptr.
    function automatic int winner(input logic [N-1:0] v, input int p);
        int best;
        int bd;
        int d;
        best = -1;
        bd   = N;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                d = (i - p + N) % N;
                if (d < bd) begin
                    bd   = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_src   = 0;
            m_ptr   = 0;
            m_took  = 1'b0;
            m_gnt   = 0;
            for (int i = 0; i < N; i++) waitc[i] = 0;
        end else begin
            int w;
            int mx;
            w      = winner(bus.req_valid, m_ptr);
            m_took = 1'b0;
            if ((!m_valid || bus.out_ready) && w >= 0) begin
                mx = 0;
                for (int i = 0; i < N; i++) begin
                    if (i == w || !bus.req_valid[i]) waitc[i] = 0;
                    else waitc[i]++;
                    if (waitc[i] > mx) mx = waitc[i];
                end
                chk("fairness", 32'(mx <= N - 1), 32'd1);
                m_took  = 1'b1;
                m_gnt   = w;
                m_valid = 1'b1;
                m_data  = bus.req_data[w*DW +: DW];
                m_src   = w;
                m_ptr   = (w + 1) % N;
            end else begin
                if (m_valid && bus.out_ready) m_valid = 1'b0;
                for (int i = 0; i < N; i++)
                    if (!bus.req_valid[i]) waitc[i] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            int w;
            logic [N-1:0] er;
            w  = winner(bus.req_valid, m_ptr);
            er = '0;
            if ((!m_valid || bus.out_ready) && w >= 0) er[w] = 1'b1;
            chk("m_req_ready", 32'(bus.req_ready), 32'(er));
            chk("m_out_valid", 32'(bus.out_valid), 32'(m_valid));
            chk("m_out_data", 32'(bus.out_data), 32'(m_data));
            chk("m_out_src", 32'(bus.out_src), 32'(m_src));
        end
    end

    initial begin
        logic [N-1:0] cv;
        int exp3 [3];
        exp3 = '{3, 0, 3};

        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;
        run_cmp       = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_src", 32'(bus.out_src), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);

        #1;
        bus.req_valid = 4'hF;
        for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = 8'(8'hA0 + i);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t1_src", 32'(bus.out_src), 32'(k % 4));
            chk("t1_data", 32'(bus.out_data), 32'(8'hA0 + k % 4));
            chk("t1_valid", 32'(bus.out_valid), 32'd1);
        end

        #1;
        bus.req_valid = 4'b0100;
        bus.req_data[2*DW +: DW] = 8'h5C;
        @(negedge clk);
        chk("t2_data", 32'(bus.out_data), 32'h5C);
        chk("t2_src", 32'(bus.out_src), 32'd2);
        #1;
        bus.out_ready = 1'b0;
        bus.req_data[2*DW +: DW] = 8'h5D;
        repeat (5) begin
            @(negedge clk);
            chk("t2_stall_rdy", 32'(bus.req_ready), 32'd0);
            chk("t2_stall_data", 32'(bus.out_data), 32'h5C);
            chk("t2_stall_src", 32'(bus.out_src), 32'd2);
            chk("t2_stall_valid", 32'(bus.out_valid), 32'd1);
        end
        #1;
        bus.out_ready = 1'b1;
        #1;
        chk("t2_rdy", 32'(bus.req_ready), 32'b0100);
        @(negedge clk);
        chk("t2_nobubble_valid", 32'(bus.out_valid), 32'd1);
        chk("t2_nobubble_data", 32'(bus.out_data), 32'h5D);

        #1;
        bus.req_valid = 4'b0001;
        bus.req_data[0 +: DW] = 8'h30;
        @(negedge clk);
        chk("t3_pre_src", 32'(bus.out_src), 32'd0);
        #1;
        bus.req_valid = 4'b1001;
        bus.req_data[3*DW +: DW] = 8'h33;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_src", 32'(bus.out_src), 32'(exp3[k]));
        end

        #1;
        bus.req_valid = 4'hF;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("t4_pre_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t4_async_valid", 32'(bus.out_valid), 32'd0);
        chk("t4_async_data", 32'(bus.out_data), 32'd0);
        chk("t4_async_src", 32'(bus.out_src), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t4_first_src", 32'(bus.out_src), 32'd0);
        chk("t4_first_data", 32'(bus.out_data), 32'h30);

        #1;
        bus.req_valid = '0;
        @(negedge clk);
        chk("t5_drain", 32'(bus.out_valid), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("t5_idle_valid", 32'(bus.out_valid), 32'd0);
            chk("t5_idle_rdy", 32'(bus.req_ready), 32'd0);
        end
        #1;
        bus.req_valid = 4'b0010;
        bus.req_data[1*DW +: DW] = 8'h51;
        #1;
        chk("t5_rdy", 32'(bus.req_ready), 32'b0010);
        @(negedge clk);
        chk("t5_src", 32'(bus.out_src), 32'd1);
        chk("t5_data", 32'(bus.out_data), 32'h51);
        #1;
        bus.req_valid = 4'hF;
        @(negedge clk);
        chk("t5_ptr_src", 32'(bus.out_src), 32'd2);

        cv = bus.req_valid;
        repeat (10000) begin
            @(negedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (cv[i] && !(m_took && m_gnt == i)) begin
                    if ($urandom_range(0, 15) == 0) cv[i] = 1'b0;
                end else begin
                    cv[i] = ($urandom_range(0, 2) != 0);
                    bus.req_data[i*DW +: DW] = 8'($urandom);
                end
            end
            bus.req_valid = cv;
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        run_cmp = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
